// File: rtl/toggle_pkg.sv
// Shared definitions for the toggle interface: channel map, event code width,
// the priming state type and a lowest-set-bit helper used by the arbiter.
package toggle_pkg;

    localparam int CH_RESET    = 0;
    localparam int CH_TEST     = 1;
    localparam int CH_ENERGIA  = 2;
    localparam int CH_MEDICINA = 3;
    localparam int CH_FOT      = 4;
    localparam int CH_ULT      = 5;

    localparam int EVT_CODE_W  = 3;

    // PRIME_FILL waits for the synchronisers to hold real samples, PRIME_RUN detects edges.
    typedef enum logic [0:0] {
        PRIME_FILL = 1'b0,
        PRIME_RUN  = 1'b1
    } prime_state_t;

    // Index of the lowest set bit (0 when none is set).
    function automatic logic [EVT_CODE_W-1:0] lowest_set(input logic [7:0] v);
        logic [EVT_CODE_W-1:0] r;
        r = '0;
        for (int i = 7; i >= 0; i--) begin
            if (v[i]) r = EVT_CODE_W'(i);
        end
        return r;
    endfunction

endpackage

// File: rtl/toggle_event_decoder_fifo.sv
// Event queue: synchronous FIFO of channel codes.
// Handshake: an entry is consumed on a cycle where valid and ready are both high;
// head always shows the oldest entry. A push is taken when there is room or when
// a pop happens in the same cycle; push_ok tells the producer which is the case.
module event_fifo
    import toggle_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                          clk,
    input  logic                          reset_tmp,
    input  logic                          push,
    input  logic [EVT_CODE_W-1:0]         push_data,
    input  logic                          ready,
    output logic                          push_ok,
    output logic                          valid,
    output logic [EVT_CODE_W-1:0]         head,
    output logic [$clog2(DEPTH+1)-1:0]    count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [EVT_CODE_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0]      wr_ptr;
    logic [PTR_W-1:0]      rd_ptr;
    logic                  pop;
    logic                  do_push;

    assign valid   = (count != '0);
    assign pop     = valid & ready;
    assign push_ok = (count < CNT_W'(DEPTH)) | pop;
    assign do_push = push & push_ok;
    assign head    = mem[rd_ptr];

    // Storage, wrapping pointers and registered occupancy.
    always_ff @(posedge clk or posedge reset_tmp) begin
        if (reset_tmp) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (pop) rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/toggle_event_decoder.sv
// Receiver for debounced toggle levels: synchronises each channel, turns every
// level inversion into a one-cycle pulse, queues channel codes for the consumer
// and stretches a per-channel LED acknowledge.
module toggle_event_decoder
    import toggle_pkg::*;
#(
    parameter int N_CH        = 6,
    parameter int SYNC_STAGES = 2,
    parameter int FIFO_DEPTH  = 4,
    parameter int LED_HOLD    = 5
) (
    input  logic                  clk,
    input  logic                  reset_tmp,
    input  logic [N_CH-1:0]       tog_in,
    output logic [N_CH-1:0]       pulse_out,
    output logic                  evt_valid,
    output logic [EVT_CODE_W-1:0] evt_code,
    input  logic                  evt_ready,
    output logic [2:0]            fifo_count,
    output logic                  evt_overflow,
    output logic [N_CH-1:0]       led_ack
);

    localparam int FILL_W = $clog2(SYNC_STAGES + 1);
    localparam int LED_W  = $clog2(LED_HOLD + 1);
    localparam int CNT_W  = $clog2(FIFO_DEPTH + 1);

    logic [N_CH-1:0]       sync_q [SYNC_STAGES];
    logic [N_CH-1:0]       s;
    logic [N_CH-1:0]       last_q;
    prime_state_t          state_q, state_d;
    logic [FILL_W-1:0]     fill_q, fill_d;
    logic                  load_last;
    logic                  detect_en;
    logic [N_CH-1:0]       pend_q, pend_d, pend_eff;
    logic [7:0]            pend_pad;
    logic                  push_ok, push_req;
    logic [EVT_CODE_W-1:0] push_code;
    logic [CNT_W-1:0]      fifo_cnt;
    logic [LED_W-1:0]      led_cnt [N_CH];

    assign s = sync_q[SYNC_STAGES-1];

    // Synchroniser chain per channel.
    always_ff @(posedge clk or posedge reset_tmp) begin
        if (reset_tmp) begin
            for (int k = 0; k < SYNC_STAGES; k++) sync_q[k] <= '0;
        end else begin
            sync_q[0] <= tog_in;
            for (int k = 1; k < SYNC_STAGES; k++) sync_q[k] <= sync_q[k-1];
        end
    end

    // Priming state register.
    always_ff @(posedge clk or posedge reset_tmp) begin
        if (reset_tmp) begin
            state_q <= PRIME_FILL;
            fill_q  <= '0;
        end else begin
            state_q <= state_d;
            fill_q  <= fill_d;
        end
    end

    // Priming next state: wait until the chain holds post-reset samples, then
    // take the current levels as the reference so a level already high is not an event.
    always_comb begin
        state_d   = state_q;
        fill_d    = fill_q;
        load_last = 1'b0;
        detect_en = 1'b0;
        case (state_q)
            PRIME_FILL: begin
                if (fill_q == FILL_W'(SYNC_STAGES)) begin
                    load_last = 1'b1;
                    state_d   = PRIME_RUN;
                end else begin
                    fill_d = fill_q + 1'b1;
                end
            end
            PRIME_RUN: detect_en = 1'b1;
            default:   state_d   = PRIME_FILL;
        endcase
    end

    // Edge detect against the previous synchronised level; pulse is registered.
    always_ff @(posedge clk or posedge reset_tmp) begin
        if (reset_tmp) begin
            last_q    <= '0;
            pulse_out <= '0;
        end else begin
            if (load_last || detect_en) last_q <= s;
            pulse_out <= detect_en ? (s ^ last_q) : '0;
        end
    end

    assign pend_eff = pend_q | pulse_out;
    assign pend_pad = 8'(pend_eff);
    assign push_req = (|pend_eff) & push_ok;

    // Arbiter: lowest pending channel wins the single push slot of the cycle.
    always_comb begin
        push_code = lowest_set(pend_pad);
        pend_d    = pend_eff;
        for (int i = 0; i < N_CH; i++) begin
            if (push_req && (push_code == EVT_CODE_W'(i))) pend_d[i] = 1'b0;
        end
    end

    // Pending bits and sticky overflow (a pulse landing on an already pending channel).
    always_ff @(posedge clk or posedge reset_tmp) begin
        if (reset_tmp) begin
            pend_q       <= '0;
            evt_overflow <= 1'b0;
        end else begin
            pend_q <= pend_d;
            if (|(pend_q & pulse_out)) evt_overflow <= 1'b1;
        end
    end

    event_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .clk       (clk),
        .reset_tmp (reset_tmp),
        .push      (push_req),
        .push_data (push_code),
        .ready     (evt_ready),
        .push_ok   (push_ok),
        .valid     (evt_valid),
        .head      (evt_code),
        .count     (fifo_cnt)
    );

    assign fifo_count = 3'(fifo_cnt);

    // LED stretch counters: a pulse (re)loads the hold, otherwise count down to zero.
    always_ff @(posedge clk or posedge reset_tmp) begin
        if (reset_tmp) begin
            for (int i = 0; i < N_CH; i++) led_cnt[i] <= '0;
        end else begin
            for (int i = 0; i < N_CH; i++) begin
                if (pulse_out[i])           led_cnt[i] <= LED_W'(LED_HOLD);
                else if (led_cnt[i] != '0)  led_cnt[i] <= led_cnt[i] - 1'b1;
            end
        end
    end

    // LED acknowledge is high while the hold counter runs.
    always_comb begin
        for (int i = 0; i < N_CH; i++) led_ack[i] = (led_cnt[i] != '0);
    end

endmodule
